mem_router: RTL and testbench
=============================

# mem_router

Parametrised memory-map router between the CPU memory port and N memory-side slaves (BIOS blockram, SDRAM, scratchpad, HW registers, …). It folds KUSEG/KSEG0/KSEG1 mirrors to a physical address and decodes it against a parameter region table. It then runs a per-slave request/wait/valid handshake with timeout, bounded retry and a bus-error response, and returns read data to the CPU under a four-phase ren/wen–ack handshake.

## Interface
- N_SLV, 4: number of slave ports.
- ADDR_W, 32: address width.
- DATA_W, 32: data width; BE_W = DATA_W/8.
- REG_BASE, {N_SLV{32'h0}}: packed N_SLV×ADDR_W physical base per slave.
- REG_SIZE, {N_SLV{32'h0}}: packed N_SLV×ADDR_W region size in bytes; 0 disables the slave.
- TIMEOUT, 100: RESP cycles before a retry is issued.
- MAX_RETRY, 2: reissues allowed before an error is signalled.
- clk  in  1  system clock, sole clock.
- rst_n  in  1  synchronous, active-low reset.
- m_addr  in  ADDR_W  CPU virtual address.
- m_wdata  in  DATA_W  write data.
- m_be  in  BE_W  byte enables.
- m_ren, m_wen  in  1  request levels, held until m_ack.
- m_ack  out  1  completion, held until ren and wen are both low.
- m_err  out  1  valid with m_ack; unmapped address or exhausted retries.
- m_rdata  out  DATA_W  read data, valid from m_ack until the next request.
- s_req  out  N_SLV  one-hot request.
- s_we  out  1  1 = write.
- s_addr  out  ADDR_W  byte offset from the selected REG_BASE.
- s_wdata  out  DATA_W  write data; s_be  out  BE_W.
- s_wait  in  N_SLV  slave cannot accept this cycle.
- s_valid  in  N_SLV  one-cycle completion pulse (reads and writes).
- s_rdata  in  N_SLV×DATA_W  read data, valid with s_valid.

## Operation
- Physical address: if m_addr ≥ 32'hFFFE_0000 (KSEG2), pass through unchanged; else m_addr & 32'h1FFF_FFFF.
- Decode: slave i hits when base_i ≤ phys < base_i+size_i. The lowest index wins on overlap. No hit means unmapped.
- States: IDLE, ISSUE, RESP, DONE.
- IDLE: on m_ren or m_wen, latch phys, the decode, wdata, be and direction, then go to ISSUE. If both are high, the read wins.
- ISSUE, unmapped: set m_err=1, m_rdata=0, go to DONE.
- ISSUE, mapped: drive s_req[sel]=1. If s_wait[sel] is high, stay. Otherwise go to RESP at the edge; s_req drops on the next cycle.
- RESP: the timeout counter increments each cycle.
  - s_valid[sel]: latch s_rdata[sel] on reads (rdata unchanged on writes), go to DONE.
  - counter == TIMEOUT-1 and retry < MAX_RETRY: retry++, counter=0, go to ISSUE.
  - counter == TIMEOUT-1 and retry == MAX_RETRY: m_err=1, m_rdata=0, go to DONE.
- DONE: m_ack=1. When m_ren and m_wen are both low, m_ack=0, clear m_err, go to IDLE.
- An s_valid from a non-selected slave, or one arriving outside RESP, is ignored.
- s_addr, s_we, s_wdata and s_be come from the latched values and stay stable for the whole transaction. Changes on m_addr mid-transaction have no effect.

## Timing
- Reset (rst_n low at an edge) aborts any state: state=IDLE. Every output is 0 next cycle: m_ack, m_err, m_rdata, s_req, s_we, s_addr, s_wdata, s_be.
- Mapped, no wait, s_valid on the first RESP cycle:
  - request sampled at edge 0;
  - s_req high in cycle 1;
  - RESP in cycle 2;
  - m_ack high in cycle 3.
- Unmapped: m_ack and m_err high in cycle 2.
- Each s_wait cycle adds 1. Timeout path: ISSUE→RESP plus TIMEOUT cycles per attempt, for (MAX_RETRY+1) attempts.
- A new request is accepted no earlier than one cycle after m_ack falls.
- The timeout counter width is $clog2(TIMEOUT+1) and it saturates.

## Structure
- Package mem_router_pkg holds:
  - state enum;
  - KSEG_MASK=32'h1FFF_FFFF and KSEG2_BASE=32'hFFFE_0000;
  - PSX map constants (BIOS 1FC0_0000/80000, MAIN 0/200000, SCPAD 1F80_0000/400, HWREG 1F80_1000/2000) for top-level parameter use.
- Sub-module mem_region_decode: combinational. Takes phys, outputs one-hot hit[N_SLV], hit_any, and offset. Parametrised identically.

## Test plan
- Read 32'h8000_0010 (slave 1 = MAIN at 0/200000), no wait, s_valid in the first RESP cycle with 32'hDEAD_BEEF → s_addr=32'h10, s_req=4'b0010, m_rdata=DEAD_BEEF, m_err=0, m_ack at cycle 3.
- Write 32'hBF80_1004 (HWREG slave 3), s_wait high for 4 cycles → s_req held 5 cycles and s_we=1 throughout. m_ack follows s_valid, and m_ack stays high until m_wen drops.
- Read 32'h1F00_0000 (unmapped) → m_ack and m_err at cycle 2, m_rdata=0.
- TIMEOUT=8, MAX_RETRY=2, slave never responds → exactly 3 s_req issues, then m_ack with m_err=1. Repeat with s_valid on attempt 2 → m_err=0 and the data is latched.
- m_ren and m_wen high together → read performed (s_we=0). A stray s_valid on slave 0 while slave 1 is selected is ignored.
- rst_n low in RESP and again in DONE → all outputs 0 next cycle, state IDLE, and the next request completes normally.

Source files
------------

// File: rtl/mem_router_pkg.sv
// Shared types and constants for the CPU memory-map router.
//   state_t        : router transaction FSM states
//   KSEG_MASK      : folds KUSEG/KSEG0/KSEG1 mirrors onto the physical space
//   KSEG2_BASE     : addresses at or above this pass through unfolded
//   PSX_*          : reference memory map for top-level parameterisation
package mem_router_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [31:0] KSEG_MASK  = 32'h1FFF_FFFF;
    localparam logic [31:0] KSEG2_BASE = 32'hFFFE_0000;

    localparam logic [31:0] PSX_BIOS_BASE  = 32'h1FC0_0000;
    localparam logic [31:0] PSX_BIOS_SIZE  = 32'h0008_0000;
    localparam logic [31:0] PSX_MAIN_BASE  = 32'h0000_0000;
    localparam logic [31:0] PSX_MAIN_SIZE  = 32'h0020_0000;
    localparam logic [31:0] PSX_SCPAD_BASE = 32'h1F80_0000;
    localparam logic [31:0] PSX_SCPAD_SIZE = 32'h0000_0400;
    localparam logic [31:0] PSX_HWREG_BASE = 32'h1F80_1000;
    localparam logic [31:0] PSX_HWREG_SIZE = 32'h0000_2000;

endpackage

// File: rtl/mem_region_decode.sv
// Combinational region decoder: matches a physical address against the
// parameter region table.
//   phys    in  ADDR_W  physical address
//   hit     out N_SLV   one-hot match (lowest index wins on overlap)
//   hit_any out 1       any region matched
//   offset  out ADDR_W  phys minus the base of the winning region (0 if none)
module mem_region_decode
    import mem_router_pkg::*;
#(
    parameter int unsigned               N_SLV    = 4,
    parameter int unsigned               ADDR_W   = 32,
    parameter logic [N_SLV*ADDR_W-1:0]   REG_BASE = '0,
    parameter logic [N_SLV*ADDR_W-1:0]   REG_SIZE = '0
) (
    input  logic [ADDR_W-1:0] phys,
    output logic [N_SLV-1:0]  hit,
    output logic              hit_any,
    output logic [ADDR_W-1:0] offset
);

    logic [N_SLV-1:0]  in_range;
    logic [ADDR_W-1:0] off_arr [N_SLV];

    // Per-region range check; the extra bit catches both a borrow (phys < base)
    // and regions that end exactly at the top of the address space.
    for (genvar g = 0; g < N_SLV; g++) begin : g_region
        localparam logic [ADDR_W-1:0] BASE = REG_BASE[g*ADDR_W +: ADDR_W];
        localparam logic [ADDR_W-1:0] SIZE = REG_SIZE[g*ADDR_W +: ADDR_W];

        logic [ADDR_W:0] diff;
        assign diff       = {1'b0, phys} - {1'b0, BASE};
        assign off_arr[g] = diff[ADDR_W-1:0];

        if (SIZE == '0) begin : g_off
            assign in_range[g] = 1'b0;
        end else begin : g_on
            assign in_range[g] = !diff[ADDR_W] && (diff < {1'b0, SIZE});
        end
    end

    // Priority select: first matching region in index order.
    always_comb begin
        hit     = '0;
        hit_any = 1'b0;
        offset  = '0;
        for (int unsigned i = 0; i < N_SLV; i++) begin
            if (in_range[i] && !hit_any) begin
                hit[i]  = 1'b1;
                hit_any = 1'b1;
                offset  = off_arr[i];
            end
        end
    end

endmodule

// File: rtl/mem_router.sv
// Memory-map router between the CPU memory port and N_SLV slaves.
// Folds segment mirrors, decodes the region, runs a per-slave
// request/wait/valid handshake with timeout and bounded retry, and answers
// the CPU with a four-phase ren/wen-ack handshake.
//   clk, rst_n                 clock, synchronous active-low reset
//   m_addr/m_wdata/m_be        CPU request payload
//   m_ren/m_wen                CPU request levels, held until m_ack
//   m_ack/m_err/m_rdata        CPU completion, error flag, read data
//   s_req/s_we/s_addr/...      slave request side (one-hot s_req)
//   s_wait/s_valid/s_rdata     slave flow control, completion and read data
module mem_router
    import mem_router_pkg::*;
#(
    parameter int unsigned             N_SLV     = 4,
    parameter int unsigned             ADDR_W    = 32,
    parameter int unsigned             DATA_W    = 32,
    parameter logic [N_SLV*ADDR_W-1:0] REG_BASE  = '0,
    parameter logic [N_SLV*ADDR_W-1:0] REG_SIZE  = '0,
    parameter int unsigned             TIMEOUT   = 100,
    parameter int unsigned             MAX_RETRY = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [ADDR_W-1:0]         m_addr,
    input  logic [DATA_W-1:0]         m_wdata,
    input  logic [DATA_W/8-1:0]       m_be,
    input  logic                      m_ren,
    input  logic                      m_wen,
    output logic                      m_ack,
    output logic                      m_err,
    output logic [DATA_W-1:0]         m_rdata,
    output logic [N_SLV-1:0]          s_req,
    output logic                      s_we,
    output logic [ADDR_W-1:0]         s_addr,
    output logic [DATA_W-1:0]         s_wdata,
    output logic [DATA_W/8-1:0]       s_be,
    input  logic [N_SLV-1:0]          s_wait,
    input  logic [N_SLV-1:0]          s_valid,
    input  logic [N_SLV*DATA_W-1:0]   s_rdata
);

    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    localparam int unsigned RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [RTY_W-1:0] RTY_LAST = RTY_W'(MAX_RETRY);

    // Segment fold: KSEG2 passes through, everything else drops the top bits.
    logic [ADDR_W-1:0] phys;
    assign phys = (m_addr >= ADDR_W'(KSEG2_BASE)) ? m_addr
                                                  : (m_addr & ADDR_W'(KSEG_MASK));

    logic [N_SLV-1:0]  dec_hit;
    logic              dec_hit_any;
    logic [ADDR_W-1:0] dec_offset;

    mem_region_decode #(
        .N_SLV    (N_SLV),
        .ADDR_W   (ADDR_W),
        .REG_BASE (REG_BASE),
        .REG_SIZE (REG_SIZE)
    ) u_decode (
        .phys    (phys),
        .hit     (dec_hit),
        .hit_any (dec_hit_any),
        .offset  (dec_offset)
    );

    state_t            state_q, state_d;
    logic [N_SLV-1:0]  sel_q, sel_d;
    logic              mapped_q, mapped_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [RTY_W-1:0]  rty_q, rty_d;

    logic              ack_d, err_d, we_d;
    logic [DATA_W-1:0] rdata_d, wdata_d;
    logic [N_SLV-1:0]  req_d;
    logic [ADDR_W-1:0] addr_d;
    logic [BE_W-1:0]   be_d;

    // Selected-slave views of the slave inputs; other slaves are ignored.
    logic              sel_wait_c, sel_valid_c;
    logic [DATA_W-1:0] sel_rdata_c;

    assign sel_wait_c  = |(s_wait  & sel_q);
    assign sel_valid_c = |(s_valid & sel_q);

    always_comb begin
        sel_rdata_c = '0;
        for (int unsigned i = 0; i < N_SLV; i++) begin
            if (sel_q[i]) begin
                sel_rdata_c = sel_rdata_c | s_rdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        mapped_d = mapped_q;
        cnt_d    = cnt_q;
        rty_d    = rty_q;
        ack_d    = m_ack;
        err_d    = m_err;
        rdata_d  = m_rdata;
        req_d    = '0;
        we_d     = s_we;
        addr_d   = s_addr;
        wdata_d  = s_wdata;
        be_d     = s_be;

        case (state_q)
            IDLE: begin
                if (m_ren || m_wen) begin
                    state_d  = ISSUE;
                    sel_d    = dec_hit;
                    mapped_d = dec_hit_any;
                    we_d     = m_wen && !m_ren;
                    addr_d   = dec_offset;
                    wdata_d  = m_wdata;
                    be_d     = m_be;
                    cnt_d    = '0;
                    rty_d    = '0;
                    req_d    = dec_hit;
                end
            end

            ISSUE: begin
                cnt_d = '0;
                if (!mapped_q) begin
                    state_d = DONE;
                    ack_d   = 1'b1;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end else if (sel_wait_c) begin
                    req_d = sel_q;
                end else begin
                    state_d = RESP;
                end
            end

            RESP: begin
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                // A completion in the last timeout cycle still counts.
                if (sel_valid_c) begin
                    state_d = DONE;
                    ack_d   = 1'b1;
                    if (!s_we) begin
                        rdata_d = sel_rdata_c;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    if (rty_q < RTY_LAST) begin
                        state_d = ISSUE;
                        rty_d   = rty_q + RTY_W'(1);
                        cnt_d   = '0;
                        req_d   = sel_q;
                    end else begin
                        state_d = DONE;
                        ack_d   = 1'b1;
                        err_d   = 1'b1;
                        rdata_d = '0;
                    end
                end
            end

            DONE: begin
                if (!m_ren && !m_wen) begin
                    state_d = IDLE;
                    ack_d   = 1'b0;
                    err_d   = 1'b0;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sel_q    <= '0;
            mapped_q <= 1'b0;
            cnt_q    <= '0;
            rty_q    <= '0;
            m_ack    <= 1'b0;
            m_err    <= 1'b0;
            m_rdata  <= '0;
            s_req    <= '0;
            s_we     <= 1'b0;
            s_addr   <= '0;
            s_wdata  <= '0;
            s_be     <= '0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            mapped_q <= mapped_d;
            cnt_q    <= cnt_d;
            rty_q    <= rty_d;
            m_ack    <= ack_d;
            m_err    <= err_d;
            m_rdata  <= rdata_d;
            s_req    <= req_d;
            s_we     <= we_d;
            s_addr   <= addr_d;
            s_wdata  <= wdata_d;
            s_be     <= be_d;
        end
    end

endmodule

// File: tb/tb_mem_router.sv
// Self-checking bench for mem_router on the PSX memory map.
module tb_mem_router;
    import mem_router_pkg::*;

    localparam int unsigned N_SLV     = 4;
    localparam int unsigned ADDR_W    = 32;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned BE_W      = 4;
    localparam int unsigned TIMEOUT   = 8;
    localparam int unsigned MAX_RETRY = 2;

    localparam logic [N_SLV*ADDR_W-1:0] REG_BASE =
        {PSX_HWREG_BASE, PSX_SCPAD_BASE, PSX_MAIN_BASE, PSX_BIOS_BASE};
    localparam logic [N_SLV*ADDR_W-1:0] REG_SIZE =
        {PSX_HWREG_SIZE, PSX_SCPAD_SIZE, PSX_MAIN_SIZE, PSX_BIOS_SIZE};

    logic                    clk;
    logic                    rst_n;
    logic [ADDR_W-1:0]       m_addr;
    logic [DATA_W-1:0]       m_wdata;
    logic [BE_W-1:0]         m_be;
    logic                    m_ren, m_wen;
    logic                    m_ack, m_err;
    logic [DATA_W-1:0]       m_rdata;
    logic [N_SLV-1:0]        s_req;
    logic                    s_we;
    logic [ADDR_W-1:0]       s_addr;
    logic [DATA_W-1:0]       s_wdata;
    logic [BE_W-1:0]         s_be;
    logic [N_SLV-1:0]        s_wait, s_valid;
    logic [N_SLV*DATA_W-1:0] s_rdata;

    mem_router #(
        .N_SLV     (N_SLV),
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .REG_BASE  (REG_BASE),
        .REG_SIZE  (REG_SIZE),
        .TIMEOUT   (TIMEOUT),
        .MAX_RETRY (MAX_RETRY)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_be    (m_be),
        .m_ren   (m_ren),
        .m_wen   (m_wen),
        .m_ack   (m_ack),
        .m_err   (m_err),
        .m_rdata (m_rdata),
        .s_req   (s_req),
        .s_we    (s_we),
        .s_addr  (s_addr),
        .s_wdata (s_wdata),
        .s_be    (s_be),
        .s_wait  (s_wait),
        .s_valid (s_valid),
        .s_rdata (s_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference memory map, written out independently of the RTL.
    longint mdl_base [4] = '{64'h1FC0_0000, 64'h0, 64'h1F80_0000, 64'h1F80_1000};
    longint mdl_size [4] = '{64'h8_0000, 64'h20_0000, 64'h400, 64'h2000};

    logic [31:0] last_rdata;

    // Returns winning slave index or -1; off gets the byte offset.
    function automatic int mdl_decode(input logic [31:0] va, output logic [31:0] off);
        longint phys;
        phys = (va >= 32'hFFFE_0000) ? longint'(va) : longint'(va & 32'h1FFF_FFFF);
        off  = 32'h0;
        for (int i = 0; i < 4; i++) begin
            if (phys >= mdl_base[i] && phys < mdl_base[i] + mdl_size[i]) begin
                off = 32'(phys - mdl_base[i]);
                return i;
            end
        end
        return -1;
    endfunction

    // One CPU transaction with the bench acting as the slaves.
    // resp_att: attempt number (1-based) on which the slave answers; 0 = never.
    task automatic run_txn(input string nm, input logic [31:0] va, input logic ren,
                           input logic wen, input logic [31:0] wdata, input logic [3:0] be,
                           input int wait_cyc, input int resp_att, input int resp_dly,
                           input logic [31:0] rdval, input bit stray, input int hold);
        logic [31:0] off, exp_rdata;
        logic [3:0]  oh, prev_req;
        logic        exp_we, exp_err;
        int          sel, exp_att, exp_ack, issues, req_cyc, waits_left, resp_cnt, attempt, j;
        bit          acked;

        sel    = mdl_decode(va, off);
        exp_we = wen && !ren;
        if (sel < 0) begin
            oh = 4'b0; exp_err = 1'b1; exp_rdata = 32'h0; exp_att = 0; exp_ack = 2;
        end else begin
            oh = 4'(1 << sel);
            if (resp_att >= 1 && resp_att <= int'(MAX_RETRY) + 1) begin
                exp_att   = resp_att;
                exp_err   = 1'b0;
                exp_rdata = exp_we ? last_rdata : rdval;
                exp_ack   = 1 + wait_cyc + (resp_att - 1) * (1 + int'(TIMEOUT)) + 2 + resp_dly;
            end else begin
                exp_att   = int'(MAX_RETRY) + 1;
                exp_err   = 1'b1;
                exp_rdata = 32'h0;
                exp_ack   = 1 + wait_cyc + exp_att * (1 + int'(TIMEOUT));
            end
        end

        m_addr = va; m_ren = ren; m_wen = wen; m_wdata = wdata; m_be = be;
        acked = 0; issues = 0; req_cyc = 0; waits_left = wait_cyc;
        prev_req = 4'b0; resp_cnt = -1; attempt = 0;

        for (int cyc = 1; cyc <= 300 && !acked; cyc++) begin
            @(negedge clk);
            s_wait  = 4'b0;
            s_valid = 4'b0;
            m_addr  = $urandom;
            if (m_ack) begin
                acked = 1;
                check({nm, ".ack_cycle"}, 64'(cyc), 64'(exp_ack));
                check({nm, ".err"}, m_err, exp_err);
                check({nm, ".rdata"}, m_rdata, exp_rdata);
                check({nm, ".issues"}, 64'(issues), 64'(exp_att));
                check({nm, ".req_cycles"}, 64'(req_cyc), 64'(sel < 0 ? 0 : exp_att + wait_cyc));
            end else begin
                if (s_req != 4'b0) begin
                    if (prev_req == 4'b0) begin
                        issues++;
                        attempt++;
                    end
                    req_cyc++;
                    resp_cnt = -1;
                    check({nm, ".s_req"}, s_req, oh);
                    check({nm, ".s_we"}, s_we, exp_we);
                    check({nm, ".s_addr"}, s_addr, off);
                    check({nm, ".s_wdata"}, {s_wdata, s_be}, {wdata, be});
                    if (attempt == 1 && waits_left > 0) begin
                        s_wait = oh;
                        waits_left--;
                    end else if (stray && $urandom_range(0, 1) == 1) begin
                        s_valid = oh;
                    end
                end else if (prev_req != 4'b0) begin
                    resp_cnt = 0;
                end else if (resp_cnt >= 0) begin
                    resp_cnt++;
                end
                if (sel >= 0 && resp_cnt >= 0 && attempt == resp_att && resp_cnt == resp_dly) begin
                    s_valid = oh;
                    s_rdata[sel*32 +: 32] = rdval;
                end
                if (stray) begin
                    j = int'($urandom_range(0, 3));
                    if (j != sel) begin
                        s_valid[j] = 1'b1;
                        s_wait[j]  = 1'b1;
                        s_rdata[j*32 +: 32] = $urandom;
                    end
                end
            end
            prev_req = s_req;
        end
        check({nm, ".acked"}, 64'(acked), 64'd1);

        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check({nm, ".ack_hold"}, {m_ack, m_err}, {1'b1, exp_err});
        end
        m_ren = 1'b0;
        m_wen = 1'b0;
        @(negedge clk);
        check({nm, ".ack_fall"}, {m_ack, m_err}, 2'b00);
        last_rdata = exp_rdata;
    endtask

    task automatic check_zero(input string nm);
        check({nm, ".ctl"}, {m_ack, m_err, s_we, s_req}, 7'b0);
        check({nm, ".m_rdata"}, m_rdata, 32'h0);
        check({nm, ".s_addr"}, s_addr, 32'h0);
        check({nm, ".s_wdata"}, {s_wdata, s_be}, 36'h0);
    endtask

    // Reset while the read to MAIN is in RESP, or after it reached DONE.
    task automatic reset_mid(input string nm, input bit in_done);
        m_addr = 32'h8000_0100; m_ren = 1'b1; m_wen = 1'b0; m_be = 4'hF;
        @(negedge clk);
        check({nm, ".req"}, s_req, 4'b0010);
        @(negedge clk);
        check({nm, ".resp"}, {m_ack, s_req}, 5'b0);
        if (in_done) begin
            s_valid = 4'b0010;
            s_rdata[63:32] = 32'h0BAD_CAFE;
            @(negedge clk);
            s_valid = 4'b0;
            check({nm, ".ack"}, m_ack, 1'b1);
            check({nm, ".data"}, m_rdata, 32'h0BAD_CAFE);
        end
        rst_n = 1'b0;
        m_ren = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_zero(nm);
        last_rdata = 32'h0;
    endtask

    function automatic logic [31:0] rand_addr();
        int          r;
        logic [31:0] phys;
        logic [31:0] segs [3] = '{32'h0000_0000, 32'h8000_0000, 32'hA000_0000};
        r = int'($urandom_range(0, 6));
        if (r < 4) begin
            phys = 32'(mdl_base[r]) + ($urandom_range(0, 32'(mdl_size[r]) - 1) & 32'hFFFF_FFFC);
            return phys | segs[$urandom_range(0, 2)];
        end else if (r == 4) begin
            return 32'h1F00_0000 + ($urandom & 32'h00FF_FFFC);
        end else if (r == 5) begin
            return 32'hFFFE_0000 + ($urandom & 32'h0001_FFFC);
        end
        return $urandom;
    endfunction

    initial begin
        logic ren, wen;
        rst_n = 1'b0; m_addr = '0; m_wdata = '0; m_be = '0; m_ren = 1'b0; m_wen = 1'b0;
        s_wait = '0; s_valid = '0; s_rdata = '0; last_rdata = 32'h0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;

        run_txn("rd_main",   32'h8000_0010, 1, 0, 32'h0,         4'hF, 0, 1, 0, 32'hDEAD_BEEF, 0, 0);
        run_txn("wr_hwreg",  32'hBF80_1004, 0, 1, 32'h1234_5678, 4'h3, 4, 1, 0, 32'h0,         0, 3);
        run_txn("rd_unmap",  32'h1F00_0000, 1, 0, 32'h0,         4'hF, 0, 1, 0, 32'h1111_1111, 0, 1);
        run_txn("rd_tmo",    32'h8000_0040, 1, 0, 32'h0,         4'hF, 0, 0, 0, 32'h0,         0, 0);
        run_txn("rd_retry",  32'hA000_0080, 1, 0, 32'h0,         4'hF, 0, 2, 3, 32'hCAFE_F00D, 0, 0);
        run_txn("wr_keep",   32'h1F80_0008, 0, 1, 32'h7777_0000, 4'hC, 1, 1, 7, 32'h0,         0, 0);
        run_txn("rd_wins",   32'h0000_0200, 1, 1, 32'hFFFF_FFFF, 4'hF, 0, 1, 1, 32'h0000_55AA, 1, 0);
        run_txn("rd_bios",   32'hBFC7_FFFC, 1, 0, 32'h0,         4'hF, 2, 3, 7, 32'h1357_9BDF, 1, 1);

        reset_mid("rst_resp", 0);
        run_txn("after_rst1", 32'h8000_0010, 1, 0, 32'h0, 4'hF, 0, 1, 0, 32'hA5A5_5A5A, 0, 0);
        reset_mid("rst_done", 1);
        run_txn("after_rst2", 32'h0000_0020, 1, 0, 32'h0, 4'hF, 1, 1, 2, 32'h0F0F_F0F0, 0, 0);

        for (int k = 0; k < 60; k++) begin
            ren = 1'($urandom_range(0, 1));
            wen = ren ? 1'($urandom_range(0, 1)) : 1'b1;
            run_txn("rand", rand_addr(), ren, wen, $urandom, 4'($urandom),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, TIMEOUT - 1)), $urandom,
                    1'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
